btn_debounce: RTL and testbench



---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_debounce_ch.sv | 126 ++++++++++++
 rtl/btn_debounce.sv | 46 ++++
 tb/tb_btn_debounce.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared state encoding and counter sizing for the push-button debouncer.
// Pure declarations: no latency, no backpressure.
package btn_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  // Repeat counter must hold 0..delay; keep at least one bit when repeat is disabled.
  function automatic int rpt_width(input int delay);
    return (delay < 1) ? 1 : $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button: 2-flop sync, tick-driven debounce FSM with auto-repeat; pulses appear 1 cycle after the deciding strobe.
// No backpressure: pulses are single-cycle and are not held for a consumer.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int STABLE_SAMPLES = 2,
  parameter int REPEAT_DELAY   = 10,
  parameter int REPEAT_RATE    = 4
) (
  input  logic clk_24M,
  input  logic reset,
  input  logic clk_debounce,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int RPT_W = rpt_width(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(STABLE_SAMPLES);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RELOAD =
    RPT_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - REPEAT_RATE) : 0);

  logic             sync1_q, s_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             cnt_done, rpt_due;

  assign cnt_done = (cnt_q + CNT_W'(1)) == CNT_DONE;
  assign rpt_due  = (REPEAT_DELAY > 0) && ((rpt_q + RPT_W'(1)) == RPT_LAST);

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      s_q       <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      rpt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      s_q       <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    if (clk_debounce) begin
      unique case (state_q)
        IDLE: begin
          if (s_q) begin
            state_d = PRESS_PEND;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_PEND: begin
          if (!s_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d = HELD;
            cnt_d   = '0;
            rpt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s_q) begin
            state_d = RELEASE_PEND;
            cnt_d   = CNT_W'(1);
          end else if (REPEAT_DELAY > 0) begin
            rpt_d = rpt_due ? RPT_RELOAD : rpt_q + RPT_W'(1);
          end
        end
        RELEASE_PEND: begin
          // A bounce back to 1 returns to HELD silently and restarts the repeat timer.
          if (s_q) begin
            state_d = HELD;
            cnt_d   = '0;
            rpt_d   = '0;
          end else if (cnt_done) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    if (clk_debounce) begin
      press_d   = (state_q == PRESS_PEND)   &&  s_q && cnt_done;
      release_d = (state_q == RELEASE_PEND) && !s_q && cnt_done;
      repeat_d  = (state_q == HELD)         &&  s_q && rpt_due;
    end
  end

  assign btn_level   = (state_q == HELD) || (state_q == RELEASE_PEND);
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: rtl/btn_debounce.sv
// NUM_BTN independent debounce channels; press/release/repeat pulses 1 cycle after the deciding strobe.
// No backpressure: outputs are free-running levels and single-cycle pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTN        = 5,
  parameter int STABLE_SAMPLES = 2,
  parameter int REPEAT_DELAY   = 10,
  parameter int REPEAT_RATE    = 4
) (
  input  logic               clk_24M,
  input  logic               reset,
  input  logic               clk_debounce,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  if (STABLE_SAMPLES < 2 || STABLE_SAMPLES > (2 ** CNT_W) - 1) begin : g_bad_stable
    $error("btn_debounce: STABLE_SAMPLES=%0d outside 2..15", STABLE_SAMPLES);
  end

  if (REPEAT_DELAY > 0 && (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY)) begin : g_bad_rate
    $error("btn_debounce: REPEAT_RATE=%0d outside 1..%0d", REPEAT_RATE, REPEAT_DELAY);
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk_24M      (clk_24M),
      .reset        (reset),
      .clk_debounce (clk_debounce),
      .btn_raw      (btn_raw[i]),
      .btn_level    (btn_level[i]),
      .btn_press    (btn_press[i]),
      .btn_release  (btn_release[i]),
      .btn_repeat   (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed scenarios plus a random phase; every cycle is compared against a level/run-length/hold-time model.
module tb_btn_debounce;

  localparam int NB = 5;
  localparam int SS = 2;
  localparam int RD = 10;
  localparam int RR = 4;

  logic          clk_24M = 1'b0;
  logic          reset;
  logic          clk_debounce;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  int tests  = 0;
  int failed = 0;
  int phase;
  bit rand_mode = 1'b0;

  bit m_s1 [NB];
  bit m_s2 [NB];
  bit m_lvl[NB];
  int m_run [NB];
  int m_hold[NB];
  logic [NB-1:0] e_lvl, e_press, e_rel, e_rpt;

  btn_debounce #(
    .NUM_BTN(NB), .STABLE_SAMPLES(SS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk_24M      (clk_24M),
    .reset        (reset),
    .clk_debounce (clk_debounce),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .btn_repeat   (btn_repeat)
  );

  always #5 clk_24M = ~clk_24M;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Level flips after SS consecutive opposite samples; repeats at hold = RD, RD+RR, ...
  task automatic model_edge();
    e_press = '0; e_rel = '0; e_rpt = '0;
    for (int i = 0; i < NB; i++) begin
      if (reset) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_hold[i] = 0;
      end else begin
        if (clk_debounce) begin
          if (m_s2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == SS) begin
              m_lvl[i]  = m_s2[i];
              m_run[i]  = 0;
              m_hold[i] = 0;
              if (m_s2[i]) e_press[i] = 1'b1; else e_rel[i] = 1'b1;
            end
          end else begin
            if (m_run[i] > 0) m_hold[i] = 0;
            else if (m_lvl[i] && RD > 0) begin
              m_hold[i]++;
              if (m_hold[i] >= RD && (m_hold[i] - RD) % RR == 0) e_rpt[i] = 1'b1;
            end
            m_run[i] = 0;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = btn_raw[i];
      end
    end
    for (int i = 0; i < NB; i++) e_lvl[i] = m_lvl[i];
  endtask

  task automatic step();
    if (rand_mode) clk_debounce = ($urandom_range(0, 2) == 0);
    else           clk_debounce = (phase == 9);
    @(posedge clk_24M);
    model_edge();
    phase = (phase + 1) % 10;
    #1;
    chk("level",   btn_level,   e_lvl);
    chk("press",   btn_press,   e_press);
    chk("release", btn_release, e_rel);
    chk("repeat",  btn_repeat,  e_rpt);
  endtask

  initial begin
    int n, post, first, pulses, lvl_seen, rcount;
    logic [31:0] mask;

    reset = 1'b1; btn_raw = 5'b11111; clk_debounce = 1'b0; phase = 6;

    // Reset with buttons pressed and a strobe inside the window.
    repeat (5) step();
    chk("t1_reset_level", btn_level, 5'b00000);
    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (btn_press !== 5'b11111 && n < 40);
    chk_int("t1_press_latency", n, 19);
    btn_raw = '0;
    repeat (40) step();
    chk("t1_all_released", btn_level, 5'b00000);

    // Clean rise on ch0, 3 cycles ahead of a strobe.
    while (phase != 7) step();
    btn_raw[0] = 1'b1;
    n = 0;
    do begin step(); n++; end while (btn_press[0] !== 1'b1 && n < 40);
    chk_int("t2_press_latency", n, 13);
    chk("t2_press_only_ch0", btn_press, 5'b00001);
    step();
    chk("t2_press_width", btn_press, 5'b00000);
    chk("t2_level_held", btn_level, 5'b00001);

    // ch1 alternates every strobe: never stable for two samples.
    while (phase != 0) step();
    pulses = 0; lvl_seen = 0;
    for (int k = 0; k < 12; k++) begin
      btn_raw[1] = (k % 2 == 0);
      for (int c = 0; c < 10; c++) begin
        step();
        pulses += btn_press[1] + btn_release[1] + btn_repeat[1];
        lvl_seen += btn_level[1];
      end
    end
    btn_raw[1] = 1'b0;
    chk_int("t3_toggle_pulses", pulses, 0);
    chk_int("t3_toggle_level", lvl_seen, 0);

    // ch2 held: repeat on post-press strobes 10, 14, 18.
    btn_raw[2] = 1'b1;
    n = 0;
    do begin step(); n++; end while (btn_press[2] !== 1'b1 && n < 40);
    chk_int("t4_press_seen", btn_press[2], 1);
    post = 0; mask = '0; rcount = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (clk_debounce) post++;
      if (btn_repeat[2]) begin mask |= 32'd1 << post; rcount++; end
    end
    chk_int("t4_repeat_mask", int'(mask), (1 << 10) | (1 << 14) | (1 << 18));
    chk_int("t4_repeat_cycles", rcount, 3);
    btn_raw[2] = 1'b0;

    // ch3: one-strobe dropout while held.
    btn_raw[3] = 1'b1;
    n = 0;
    do begin step(); n++; end while (btn_press[3] !== 1'b1 && n < 40);
    chk_int("t5_press_seen", btn_press[3], 1);
    pulses = 0; lvl_seen = 0;
    repeat (10) begin step(); lvl_seen += btn_level[3]; end
    btn_raw[3] = 1'b0;
    repeat (10) begin step(); lvl_seen += btn_level[3]; pulses += btn_press[3] + btn_release[3]; end
    btn_raw[3] = 1'b1;
    repeat (10) begin step(); lvl_seen += btn_level[3]; pulses += btn_press[3] + btn_release[3]; end
    chk_int("t5_no_pulses", pulses, 0);
    chk_int("t5_level_kept", lvl_seen, 30);
    n = 0; first = 0;
    for (int c = 0; c < 150; c++) begin
      step();
      if (clk_debounce) n++;
      if (btn_repeat[3] && first == 0) first = n;
    end
    chk_int("t5_repeat_restart", first, 10);

    // ch0 and ch4 released together; reset lands during the pending release.
    btn_raw[4] = 1'b1;
    n = 0;
    do begin step(); n++; end while (btn_press[4] !== 1'b1 && n < 40);
    chk_int("t6_press_seen", btn_press[4], 1);
    btn_raw[0] = 1'b0; btn_raw[4] = 1'b0;
    repeat (10) step();
    chk("t6_pending_level", btn_level & 5'b10001, 5'b10001);
    repeat (4) step();
    reset = 1'b1;
    step();
    chk("t6_reset_level", btn_level, 5'b00000);
    chk("t6_reset_release", btn_release, 5'b00000);
    step();
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin step(); pulses += btn_release[0] + btn_release[4]; end
    chk_int("t6_no_release", pulses, 0);

    // Random raw activity, dense strobes, rare resets.
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) btn_raw[$urandom_range(0, NB - 1)] ^= 1'b1;
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
